// File: rtl/decoder_scan_ctrl.sv
// Slot scanner driving the 2-to-4 decoder select with per-slot dwell and blanking gap.
// Define DECODER_SCAN_MASK_EN to honour the per-slot skip mask; otherwise all slots scan.
module decoder_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       wrap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_LAST = 16'((BLANK > 0) ? BLANK - 1 : 0);

  if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
    $error("decoder_scan_ctrl: DWELL must be in 1..65535");
  end
  if (BLANK < 0 || BLANK > 65535) begin : g_bad_blank
    $error("decoder_scan_ctrl: BLANK must be in 0..65535");
  end

  logic [1:0]  state;
  logic [15:0] dwell_cnt;
  logic [15:0] blank_cnt;
  logic [3:0]  skip;
  logic [1:0]  first_sel;
  logic [1:0]  next_sel;
  logic [1:0]  cand_first;
  logic [1:0]  cand_next;
  logic        any_open;
  logic        advance;

`ifdef DECODER_SCAN_MASK_EN
  assign skip = mask;
`else
  logic unused_mask;
  assign skip        = 4'b0000;
  assign unused_mask = ^mask;
`endif

  // Descending scan so the lowest index / smallest forward offset is the one kept.
  always_comb begin
    first_sel  = 2'd0;
    next_sel   = sel;
    cand_first = 2'd0;
    cand_next  = 2'd0;
    any_open   = ~&skip;
    for (int unsigned i = 0; i < 4; i++) begin
      cand_first = 2'(3 - i);
      if (!skip[cand_first]) first_sel = cand_first;
      cand_next = sel + 2'(4 - i);
      if (!skip[cand_next]) next_sel = cand_next;
    end
  end

  always_comb begin
    advance = 1'b0;
    if (state == S_DWELL && dwell_cnt == DWELL_LAST && BLANK == 0) advance = 1'b1;
    if (state == S_BLANK && blank_cnt == BLANK_LAST)               advance = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state     <= S_IDLE;
        sel       <= '0;
        sel_valid <= 1'b0;
        dwell_cnt <= '0;
        blank_cnt <= '0;
      end else if (advance) begin
        dwell_cnt <= '0;
        blank_cnt <= '0;
        if (any_open) begin
          state     <= S_DWELL;
          sel       <= next_sel;
          sel_valid <= 1'b1;
          wrap      <= (next_sel <= sel);
        end else begin
          state     <= S_IDLE;
          sel       <= '0;
          sel_valid <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (any_open) begin
              state     <= S_DWELL;
              sel       <= first_sel;
              sel_valid <= 1'b1;
              dwell_cnt <= '0;
            end
          end
          S_DWELL: begin
            if (dwell_cnt == DWELL_LAST) begin
              state     <= S_BLANK;
              sel_valid <= 1'b0;
              dwell_cnt <= '0;
              blank_cnt <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + 16'd1;
            end
          end
          S_BLANK: begin
            blank_cnt <= blank_cnt + 16'd1;
          end
          default: begin
            state     <= S_IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: two instances (BLANK=1 and BLANK=0), directed vectors.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a;
  logic       en_b;
  logic [3:0] mask;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b;
  logic       wrap_a, wrap_b;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DWELL(3), .BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mask(mask),
    .sel(sel_a), .sel_valid(valid_a), .wrap(wrap_a)
  );

  decoder_scan_ctrl #(.DWELL(3), .BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mask(mask),
    .sel(sel_b), .sel_valid(valid_b), .wrap(wrap_b)
  );

  // Expected outputs packed as {sel, sel_valid, wrap}
  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [3:0] b;
    string      name;
  } exp_t;

  localparam logic [3:0] IDLE = 4'b0000;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] exp4(input int s, input bit v, input bit w);
    logic [1:0] s2;
    s2 = s[1:0];
    return {s2, v, w};
  endfunction

  // DWELL=3, BLANK=1, all slots: 4-cycle slots, wrap every 16 cycles
  function automatic logic [3:0] pa(input int k);
    return exp4((k / 4) % 4, (k % 4) < 3, (k > 0) && (k % 16 == 0));
  endfunction

  // DWELL=3, BLANK=0, all slots: 3-cycle slots, wrap every 12 cycles
  function automatic logic [3:0] pb(input int k);
    return exp4((k / 3) % 4, 1'b1, (k > 0) && (k % 12 == 0));
  endfunction

  task automatic drive(input logic r, input logic ea, input logic eb, input logic [3:0] m,
                       input logic [3:0] xa, input logic [3:0] xb, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    en_a  = ea;
    en_b  = eb;
    mask  = m;
    e.cyc  = cyc + 1;
    e.a    = xa;
    e.b    = xb;
    e.name = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL %s stale entry: got cycle %0d, expected cycle %0d", e.name, cyc, e.cyc);
      end
      if ({sel_a, valid_a, wrap_a} !== e.a) begin
        fails++;
        $display("FAIL %s dut_a cyc %0d: got sel=%0d valid=%b wrap=%b, expected sel=%0d valid=%b wrap=%b",
                 e.name, cyc, sel_a, valid_a, wrap_a, e.a[3:2], e.a[1], e.a[0]);
      end
      tests++;
      if ({sel_b, valid_b, wrap_b} !== e.b) begin
        fails++;
        $display("FAIL %s dut_b cyc %0d: got sel=%0d valid=%b wrap=%b, expected sel=%0d valid=%b wrap=%b",
                 e.name, cyc, sel_b, valid_b, wrap_b, e.b[3:2], e.b[1], e.b[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    mask  = 4'b0000;

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 4'b0000, IDLE, IDLE, "reset_hold");

    // Free scan; k=27 is A's blank cycle of slot 2
    for (int k = 0; k < 28; k++) drive(1'b1, 1'b1, 1'b1, 4'b0000, pa(k), pb(k), "basic_scan");

    // en falls on A's last blank count: abort wins, no advance or wrap
    drive(1'b1, 1'b0, 1'b0, 4'b0000, IDLE, IDLE, "abort_in_blank");
    drive(1'b1, 1'b0, 1'b0, 4'b0000, IDLE, IDLE, "abort_idle");
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, 1'b1, 4'b0000, pa(k), pb(k), "reenable");

    // A is mid-dwell of slot 1 here
    drive(1'b0, 1'b1, 1'b1, 4'b0000, IDLE, IDLE, "reset_mid_dwell");

`ifdef DECODER_SCAN_MASK_EN
    for (int k = 0; k < 21; k++)
      drive(1'b1, 1'b1, 1'b0, 4'b1010,
            exp4(((k / 4) % 2 == 1) ? 2 : 0, (k % 4) < 3, (k > 0) && (k % 8 == 0)),
            IDLE, "mask_1010");
    // All slots masked mid-dwell of slot 2: slot completes, then IDLE
    for (int k = 21; k < 27; k++)
      drive(1'b1, 1'b1, 1'b0, 4'b1111,
            (k <= 23) ? exp4(2, (k % 4) < 3, 1'b0) : IDLE, IDLE, "mask_all");
    for (int k = 0; k < 10; k++)
      drive(1'b1, 1'b1, 1'b1, 4'b1101,
            exp4(1, (k % 4) < 3, (k > 0) && (k % 4 == 0)),
            exp4(1, 1'b1, (k > 0) && (k % 3 == 0)), "single_slot");
`else
    // Mask is ignored without the feature: a fully-set mask still scans all slots
    for (int k = 0; k < 17; k++) drive(1'b1, 1'b1, 1'b1, 4'b1111, pa(k), pb(k), "mask_ignored");
`endif

    drive(1'b1, 1'b0, 1'b0, 4'b0000, IDLE, IDLE, "final_disable");
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequential scan controller that sits directly upstream of the 2-to-4 decoder and drives its 2-bit select input. It steps through slots 0-3 with a programmable dwell time per slot, inserts an optional blanking gap between slots, skips masked slots, and flags each wrap-around. Typical use is multiplexed display-digit or row scanning, where the decoder's one-hot output gates each slot.

## Interface
Parameters:
- DWELL, 4: cycles `sel_valid` stays high per slot; legal range 1..65535.
- BLANK, 1: blanking cycles between slots, with `sel_valid` low; legal range 0..65535.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  scan enable, level-sensitive.
- mask  in  4  `mask[k]=1` skips slot k; only honoured with DECODER_SCAN_MASK_EN.
- sel  out  2  slot index; connects to the decoder `i` input.
- sel_valid  out  1  high while `sel` is in its dwell window; gates the decoder output.
- wrap  out  1  one-cycle pulse when the scan wraps.

All outputs are registered.

## Operation
- Reset values: state IDLE, `sel=2'b00`, `sel_valid=0`, `wrap=0`, dwell/blank counters 0.
- Reset is synchronous and overrides everything, including mid-dwell or mid-blank.
- States: IDLE, DWELL, BLANK.
- IDLE:
  - If `en=1` and at least one slot is unmasked: go to DWELL, set `sel` to the lowest unmasked index, `sel_valid=1`.
  - Otherwise stay in IDLE.
- DWELL:
  - Counter runs 0..DWELL-1.
  - On the last count, if BLANK>0: go to BLANK, `sel_valid=0`, `sel` held.
  - On the last count, if BLANK=0: advance directly, staying in DWELL with `sel_valid` continuously high.
- BLANK:
  - Counter runs 0..BLANK-1.
  - On the last count: advance, go to DWELL, `sel_valid=1`.
- Advance:
  - Next `sel` = next unmasked index after the current one, searching modulo 4.
  - `mask` is sampled only at the advance cycle. A mask change mid-slot does not shorten the current dwell.
  - If every slot is masked at advance: go to IDLE, `sel=0`, `sel_valid=0`.
- wrap:
  - Pulses in the same cycle the new `sel` is loaded, whenever new index <= old index.
  - With a single unmasked slot, `wrap` pulses on every advance and `sel` is unchanged.
  - Never pulses on IDLE->DWELL entry.
- `en` deasserted in any state: next cycle go to IDLE, `sel=0`, `sel_valid=0`, `wrap=0`. The scan restarts from the lowest unmasked slot on re-enable.
- Counters are 16 bits wide. Out-of-range parameter values are unsupported, and a synthesis-time check fails the build.

## Timing
- `en` sampled high at edge T: `sel_valid=1` and `sel` valid from T+1. Latency is one cycle.
- Slot period is exactly DWELL+BLANK cycles. A full scan of n unmasked slots takes n*(DWELL+BLANK) cycles.
- `sel` changes only on cycles where `sel_valid` rises, or, when BLANK=0, on the slot-boundary cycle.
- `sel` never changes while `sel_valid` is high within a dwell window.
- `wrap` is high for exactly one cycle, aligned with the first dwell cycle of the wrapped-to slot.
- Simultaneous `en` fall and last-count: the `en` fall wins. Go to IDLE, and no advance or `wrap` occurs.

## Configuration
- DECODER_SCAN_MASK_EN defined:
  - `mask` is honoured as described above.
  - Skip logic is a 4-entry search from `sel+1`.
- Not defined:
  - The `mask` port still exists but is ignored and treated as 4'b0000.
  - All four slots are always scanned in order 0,1,2,3.
  - The IDLE all-masked checks reduce to constant true.

## Test plan
- Reset and enable: hold `rst_n=0` 3 cycles with `en=1`. Outputs stay `sel=0`, `sel_valid=0`, `wrap=0`. Release `rst_n`: `sel_valid=1` and `sel=0` on the next cycle.
- Basic scan, DWELL=3, BLANK=1, mask=0: `sel_valid` pattern 1,1,1,0 repeats. `sel` sequence is 0,1,2,3,0. `wrap` pulses once per 16 cycles, when `sel` returns to 0.
- BLANK=0: `sel_valid` stays high continuously. `sel` changes every 3 cycles. `wrap` pulses every 12 cycles.
- Masking (macro defined), `mask=4'b1010`: `sel` alternates 0,2,0,2, with `wrap` on each 2->0 transition. Set `mask=4'b1111` mid-dwell: the current slot completes, then IDLE with `sel_valid=0`.
- Single slot, `mask=4'b1101`: `sel` stays at 1. `wrap` pulses every DWELL+BLANK cycles.
- Mid-operation abort: drop `en` during BLANK of slot 2, giving `sel=0` and `sel_valid=0` next cycle. Re-enable: restarts at `sel=0` with no `wrap`. Assert `rst_n=0` mid-dwell: outputs are at their reset values the next cycle.
